// File: rtl/alu_req_arbiter_pkg.sv
// alu_arb_pkg: shared constants for the ALU request arbiter slice.
// Holds the FSM state encoding, ALU op select codes and default widths.
// Latency / backpressure: n/a (declarations only).
package alu_arb_pkg;

  localparam int A_W_DEF     = 4;   // operand width
  localparam int OUT_W_DEF   = 16;  // ALU result width
  localparam int ALU_LAT_DEF = 1;   // ALU register stages
  localparam int CNT_W       = 4;   // wait counter width, covers ALU_LAT up to 15

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b11;

endpackage

// File: rtl/alu_req_arbiter_if.sv
// alu_req_arbiter_if: request/response bundle between two requesters and the arbiter.
// Ports: req_valid/req_ready/req_a/req_b/req_sel (request), rsp_valid/rsp_ready/rsp_out/rsp_cout (response).
// master = requester side, slave = arbiter side; per-requester fields are packed, requester i at slot i.
interface alu_req_arbiter_if
  import alu_arb_pkg::*;
#(
  parameter int A_W   = A_W_DEF,
  parameter int OUT_W = OUT_W_DEF
);

  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [2*A_W-1:0] req_a;
  logic [2*A_W-1:0] req_b;
  logic [3:0]       req_sel;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [OUT_W-1:0] rsp_out;
  logic             rsp_cout;

  modport master (
    output req_valid, req_a, req_b, req_sel, rsp_ready,
    input  req_ready, rsp_valid, rsp_out, rsp_cout
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sel, rsp_ready,
    output req_ready, rsp_valid, rsp_out, rsp_cout
  );

endinterface

// File: rtl/alu_req_arbiter_rr_arb2.sv
// rr_arb2: combinational 2-way round-robin grant; ptr names the favoured requester.
// Ports: req[1:0] in, ptr in, gnt[1:0] out (one-hot or zero). Latency: 0 cycles.
// Backpressure: none; the caller decides when a grant is consumed.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req[ptr]) begin
      gnt[ptr] = 1'b1;
    end else if (req[~ptr]) begin
      gnt[~ptr] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one registered ALU between two requesters, one op in flight.
// Latency: accept at T -> rsp_valid at T+ALU_LAT+2; issue interval ALU_LAT+3 cycles minimum.
// Backpressure: rsp held until rsp_ready[owner]; req_ready stays low while an op is in flight.
// Ports: clk, rst (sync, active-high), bus (slave modport: req/rsp handshakes),
//        alu_a/alu_b/alu_sel to the ALU, alu_out/alu_cout from the ALU.
// Optional: define ALU_ARB_STATS_EN to add stat_ops[31:0] (per-requester completed-response counts).
module alu_req_arbiter
  import alu_arb_pkg::*;
#(
  parameter int A_W     = A_W_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int ALU_LAT = ALU_LAT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  alu_req_arbiter_if.slave bus,
  output logic [A_W-1:0]   alu_a,
  output logic [A_W-1:0]   alu_b,
  output logic [1:0]       alu_sel,
  input  logic [OUT_W-1:0] alu_out,
  input  logic             alu_cout
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [31:0]      stat_ops
`endif
);

  state_t           state;
  state_t           state_nxt;
  logic             ptr;
  logic             owner;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       gnt;
  logic [1:0]       req_ready_c;
  logic [1:0]       rsp_valid_c;
  logic [OUT_W-1:0] rsp_out_q;
  logic             rsp_cout_q;
  logic             rsp_hs;

  rr_arb2 u_rr_arb2 (
    .req (bus.req_valid),
    .ptr (ptr),
    .gnt (gnt)
  );

  // Only the owner's ready bit can complete the response.
  assign rsp_hs = (state == RESP) && bus.rsp_ready[owner];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|gnt)          state_nxt = WAIT;
      WAIT:    if (cnt == '0)     state_nxt = RESP;
      RESP:    if (rsp_hs)        state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Handshake outputs.
  always_comb begin
    req_ready_c = 2'b00;
    rsp_valid_c = 2'b00;
    if (state == IDLE) begin
      req_ready_c = gnt;
    end
    if (state == RESP) begin
      rsp_valid_c = owner ? 2'b10 : 2'b01;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_out   = rsp_out_q;
  assign bus.rsp_cout  = rsp_cout_q;

  // Datapath: operand capture, ALU wait countdown, result capture, pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= 1'b0;
      owner      <= 1'b0;
      cnt        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= 2'b00;
      rsp_out_q  <= '0;
      rsp_cout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|gnt) begin
            owner   <= gnt[1];
            alu_a   <= gnt[1] ? bus.req_a[A_W +: A_W] : bus.req_a[0 +: A_W];
            alu_b   <= gnt[1] ? bus.req_b[A_W +: A_W] : bus.req_b[0 +: A_W];
            alu_sel <= gnt[1] ? bus.req_sel[3:2]      : bus.req_sel[1:0];
            cnt     <= CNT_W'(ALU_LAT);
          end
        end
        WAIT: begin
          // Counter runs ALU_LAT..0, so WAIT spans ALU_LAT+1 cycles and the
          // ALU output has settled on the cycle it reaches zero.
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rsp_out_q  <= alu_out;
            rsp_cout_q <= alu_cout;
          end
        end
        RESP: begin
          if (rsp_hs) begin
            ptr <= ~owner;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [15:0] ops0;
  logic [15:0] ops1;

  // Saturating per-requester completion counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      ops0 <= '0;
      ops1 <= '0;
    end else if (rsp_hs) begin
      if (!owner && ops0 != 16'hFFFF) ops0 <= ops0 + 16'd1;
      if (owner  && ops1 != 16'hFFFF) ops1 <= ops1 + 16'd1;
    end
  end

  assign stat_ops = {ops1, ops0};
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference (grant rule, accept->response timing, result arithmetic).
// Bench ALU: one register stage; ADD, MUL and two extra ops to vary results.
module tb_alu_req_arbiter;
  import alu_arb_pkg::*;

  localparam int LAT = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_req_arbiter_if #(.A_W(4), .OUT_W(16)) bus ();

  logic [3:0]  alu_a;
  logic [3:0]  alu_b;
  logic [1:0]  alu_sel;
  logic [15:0] alu_out  = '0;
  logic        alu_cout = 1'b0;
`ifdef ALU_ARB_STATS_EN
  logic [31:0] stat_ops;
`endif

  alu_req_arbiter #(.A_W(4), .OUT_W(16), .ALU_LAT(LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_sel  (alu_sel),
    .alu_out  (alu_out),
    .alu_cout (alu_cout)
`ifdef ALU_ARB_STATS_EN
    ,
    .stat_ops (stat_ops)
`endif
  );

  function automatic logic [16:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
    int unsigned x;
    int unsigned y;
    x = a;
    y = b;
    case (s)
      OP_ADD:  return {(x + y) > 15, 16'(x + y)};
      OP_MUL:  return {1'b0, 16'(x * y)};
      2'b01:   return {x < y, 16'(x - y)};
      default: return {1'b0, 16'(x * 16 + y)};
    endcase
  endfunction

  always @(posedge clk) {alu_cout, alu_out} <= alu_fn(alu_a, alu_b, alu_sel);

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Requester stimulus state.
  logic [1:0] pend = 2'b00;
  logic [1:0] rdy  = 2'b11;
  logic [3:0] op_a [2];
  logic [3:0] op_b [2];
  logic [1:0] op_s [2];
  int         remaining [2];

  // Reference model state.
  bit          m_busy;
  int          m_owner;
  int          m_acc;
  int          m_ptr;
  logic [3:0]  m_a;
  logic [3:0]  m_b;
  logic [1:0]  m_s;
  logic [16:0] m_res;
  int          m_stat [2];
  int          cyc;

  // Observed transactions.
  int          obs_g [$];
  int          obs_acc [$];
  int          obs_rsp_cyc [$];
  logic [15:0] obs_out [$];

  task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
    op_a[i] = a;
    op_b[i] = b;
    op_s[i] = s;
  endtask

  task automatic new_op(input int i);
    set_op(i, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
  endtask

  task automatic clear_obs();
    obs_g.delete();
    obs_acc.delete();
    obs_rsp_cyc.delete();
    obs_out.delete();
  endtask

  // One clock cycle: drive inputs, check against the model, advance.
  task automatic step();
    logic [1:0] eg;
    bit         was_rst;
    bus.req_valid = pend;
    bus.req_a     = {op_a[1], op_a[0]};
    bus.req_b     = {op_b[1], op_b[0]};
    bus.req_sel   = {op_s[1], op_s[0]};
    bus.rsp_ready = rdy;
    #1;
    was_rst = rst;
    if (!was_rst) begin
      if (!m_busy) begin
        eg = 2'b00;
        if (pend[m_ptr])          eg[m_ptr]     = 1'b1;
        else if (pend[1 - m_ptr]) eg[1 - m_ptr] = 1'b1;
        check("req_ready", bus.req_ready, eg);
        check("rsp_valid_idle", bus.rsp_valid, 0);
        if (eg != 2'b00) begin
          m_busy  = 1'b1;
          m_owner = eg[1] ? 1 : 0;
          m_acc   = cyc;
          m_a     = op_a[m_owner];
          m_b     = op_b[m_owner];
          m_s     = op_s[m_owner];
          m_res   = alu_fn(m_a, m_b, m_s);
        end
      end else if (cyc < m_acc + LAT + 2) begin
        check("req_ready_wait", bus.req_ready, 0);
        check("rsp_valid_wait", bus.rsp_valid, 0);
        check("alu_a", alu_a, m_a);
        check("alu_b", alu_b, m_b);
        check("alu_sel", alu_sel, m_s);
      end else begin
        check("rsp_valid", bus.rsp_valid, (m_owner == 1) ? 2'b10 : 2'b01);
        check("rsp_out", bus.rsp_out, m_res[15:0]);
        check("rsp_cout", bus.rsp_cout, m_res[16]);
        check("req_ready_resp", bus.req_ready, 0);
        check("alu_a_hold", alu_a, m_a);
        if (rdy[m_owner]) begin
          m_busy = 1'b0;
          m_ptr  = 1 - m_owner;
          if (m_stat[m_owner] < 65535) m_stat[m_owner]++;
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (bus.req_valid[i] && bus.req_ready[i] && !was_rst) begin
        obs_g.push_back(i);
        obs_acc.push_back(cyc);
        if (remaining[i] > 0) begin
          remaining[i]--;
          new_op(i);
        end else begin
          pend[i] = 1'b0;
        end
      end
      if (bus.rsp_valid[i] && bus.rsp_ready[i] && !was_rst) begin
        obs_out.push_back(bus.rsp_out);
        obs_rsp_cyc.push_back(cyc);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (was_rst) begin
      m_busy  = 1'b0;
      m_ptr   = 0;
      m_stat  = '{0, 0};
    end
  endtask

  task automatic do_reset();
    pend      = 2'b00;
    remaining = '{0, 0};
    rst       = 1'b1;
    step();
    rst       = 1'b0;
    bus.req_valid = 2'b00;
    #1;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_out", bus.rsp_out, 0);
    check("rst_rsp_cout", bus.rsp_cout, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_sel", alu_sel, 0);
`ifdef ALU_ARB_STATS_EN
    check("rst_stat_ops", stat_ops, 0);
`endif
    clear_obs();
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while ((m_busy || pend != 2'b00) && n < max_cyc) begin
      step();
      n++;
    end
    if (m_busy || pend != 2'b00) check("drain_timeout", 1, 0);
  endtask

  initial begin
    cyc = 0;
    set_op(0, 4'd0, 4'd0, 2'b00);
    set_op(1, 4'd0, 4'd0, 2'b00);
    remaining = '{0, 0};
    m_stat    = '{0, 0};

    // Scenario 1: single request from requester 0.
    do_reset();
    rdy = 2'b11;
    set_op(0, 4'd1, 4'd2, OP_ADD);
    pend = 2'b01;
    step();
    check("s1_alu_a", alu_a, 1);
    check("s1_alu_b", alu_b, 2);
    drain(20);
    check("s1_n", obs_out.size(), 1);
    if (obs_out.size() == 1 && obs_acc.size() == 1) begin
      check("s1_out", obs_out[0], 3);
      check("s1_latency", obs_rsp_cyc[0] - obs_acc[0], LAT + 2);
    end

    // Scenario 2: simultaneous requests after reset.
    do_reset();
    set_op(0, 4'd3, 4'd4, OP_ADD);
    set_op(1, 4'd9, 4'd10, OP_MUL);
    pend = 2'b11;
    drain(30);
    check("s2_n", obs_out.size(), 2);
    if (obs_out.size() == 2 && obs_g.size() == 2) begin
      check("s2_first", obs_g[0], 0);
      check("s2_second", obs_g[1], 1);
      check("s2_out0", obs_out[0], 7);
      check("s2_out1", obs_out[1], 90);
    end

    // Scenario 3: continuous load from both, 8 operations.
    do_reset();
    new_op(0);
    new_op(1);
    remaining = '{3, 3};
    pend = 2'b11;
    drain(100);
    check("s3_n", obs_g.size(), 8);
    for (int k = 0; k < obs_g.size(); k++) begin
      check("s3_order", obs_g[k], k % 2);
      if (k > 0) check("s3_interval", obs_acc[k] - obs_acc[k-1], LAT + 3);
    end

    // Scenario 4: response backpressure with the other requester waiting.
    do_reset();
    set_op(1, 4'd15, 4'd15, OP_MUL);
    pend = 2'b10;
    rdy  = 2'b00;
    repeat (3) step();
    set_op(0, 4'd7, 4'd7, OP_ADD);
    pend[0] = 1'b1;
    repeat (5) begin
      step();
      check("s4_rsp_valid", bus.rsp_valid, 2'b10);
      check("s4_rsp_out", bus.rsp_out, 225);
      check("s4_rsp_cout", bus.rsp_cout, 0);
      check("s4_req_ready", bus.req_ready, 0);
      check("s4_alu_a", alu_a, 15);
    end
    rdy = 2'b11;
    drain(30);
    check("s4_n", obs_out.size(), 2);
    if (obs_out.size() == 2 && obs_g.size() == 2) begin
      check("s4_order", obs_g[0] * 2 + obs_g[1], 2);
      check("s4_out0", obs_out[0], 225);
      check("s4_out1", obs_out[1], 14);
    end

    // Scenario 5: reset on the second WAIT cycle abandons the op.
    do_reset();
    set_op(0, 4'd5, 4'd6, OP_MUL);
    pend = 2'b01;
    step();
    step();
    pend = 2'b00;
    rst  = 1'b1;
    step();
    rst  = 1'b0;
    check("s5_req_ready", bus.req_ready, 0);
    check("s5_rsp_valid", bus.rsp_valid, 0);
    check("s5_rsp_out", bus.rsp_out, 0);
    check("s5_rsp_cout", bus.rsp_cout, 0);
    check("s5_alu_a", alu_a, 0);
    check("s5_alu_b", alu_b, 0);
    check("s5_alu_sel", alu_sel, 0);
    repeat (6) step();
    check("s5_no_rsp", obs_out.size(), 0);
    clear_obs();
    set_op(0, 4'd2, 4'd3, OP_ADD);
    set_op(1, 4'd4, 4'd5, OP_ADD);
    pend = 2'b11;
    step();
    check("s5_regrant_n", obs_g.size(), 1);
    if (obs_g.size() == 1) check("s5_regrant", obs_g[0], 0);
    drain(30);

`ifdef ALU_ARB_STATS_EN
    // Scenario 6: completion counters.
    do_reset();
    new_op(0);
    remaining = '{2, 0};
    pend = 2'b01;
    drain(50);
    new_op(1);
    remaining = '{0, 1};
    pend = 2'b10;
    drain(50);
    check("s6_stat_ops", stat_ops, 32'h0002_0003);
    do_reset();
`endif

    // Randomized traffic with random response backpressure.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          new_op(i);
          pend[i] = 1'b1;
        end
      end
      rdy = 2'($urandom_range(0, 3));
      step();
    end
    rdy = 2'b11;
    drain(60);
`ifdef ALU_ARB_STATS_EN
    check("rand_stat_ops", stat_ops, {16'(m_stat[1]), 16'(m_stat[0])});
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
